// File: rtl/pipe_credit_fifo.sv
// Credit-managed FIFO sitting behind a fixed-latency pipeline: hands out one credit per
// launched item and reclaims it when the item leaves through the output handshake.
module pipe_credit_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       issue_ready,
  input  logic                       issue_fire,
  input  logic                       pipe_valid_i,
  input  logic [WIDTH-1:0]           pipe_data_i,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     credits,
  output logic                       err_overflow,
  output logic                       err_issue
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, credits_q, credits_d;
  logic             err_overflow_q, err_overflow_d, err_issue_q, err_issue_d;
  logic             rd_en, wr_en, full, issue_acc;

  assign out_valid    = (count_q != '0);
  assign out_data     = mem[rd_ptr_q];
  assign issue_ready  = (credits_q != '0);
  assign count        = count_q;
  assign credits      = credits_q;
  assign err_overflow = err_overflow_q;
  assign err_issue    = err_issue_q;

  assign full      = (count_q == DepthC);
  assign rd_en     = out_valid && out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en     = pipe_valid_i && (!full || rd_en);
  assign issue_acc = issue_fire && issue_ready;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    credits_d      = credits_q;
    err_overflow_d = err_overflow_q;
    err_issue_d    = err_issue_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

    if (wr_en && !rd_en)      count_d = count_q + CW'(1);
    else if (rd_en && !wr_en) count_d = count_q - CW'(1);

    // Credits saturate at DEPTH so handshakes on un-issued items cannot overrun the counter.
    if (issue_acc && !rd_en)                           credits_d = credits_q - CW'(1);
    else if (rd_en && !issue_acc && credits_q != DepthC) credits_d = credits_q + CW'(1);

    if (pipe_valid_i && !wr_en) err_overflow_d = 1'b1;
    if (issue_fire && !issue_ready) err_issue_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      credits_q      <= DepthC;
      err_overflow_q <= 1'b0;
      err_issue_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      credits_q      <= credits_d;
      err_overflow_q <= err_overflow_d;
      err_issue_q    <= err_issue_d;
    end
  end

  // Storage is not reset; out_valid gates its visibility.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr_q] <= pipe_data_i;
  end

endmodule

// File: doc/pipe_credit_fifo.md
PIPE_CREDIT_FIFO -- requirements
Module: pipe_credit_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, at least 2.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port issue_ready  output  1  a credit is available, so upstream may launch one item into the fixed-latency pipeline.
REQ-006 The block SHALL have port issue_fire  input  1  upstream launches one item this cycle.
REQ-007 The block SHALL have port pipe_valid_i  input  1  delayed valid from the pipeline output.
REQ-008 The block SHALL have port pipe_data_i  input  WIDTH  pipeline output data.
REQ-009 The block SHALL have port out_valid  output  1  head entry available downstream.
REQ-010 The block SHALL have port out_data  output  WIDTH  head entry data.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-012 The block SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-013 The block SHALL have port credits  output  $clog2(DEPTH)+1  free credits.
REQ-014 The block SHALL have port err_overflow  output  1  sticky flag: an item was dropped because the FIFO was full.
REQ-015 The block SHALL have port err_issue  output  1  sticky flag: issue_fire was asserted with no credit.

Function
REQ-016 credits SHALL decrement by 1 on an accepted issue (issue_fire && issue_ready).
REQ-017 credits SHALL increment by 1 on an output handshake (out_valid && out_ready).
REQ-018 When an accepted issue and an output handshake occur in the same cycle, credits SHALL be unchanged.
REQ-019 issue_ready SHALL equal (credits != 0) and SHALL be derived combinationally from the registered credit counter.
REQ-020 issue_fire while issue_ready=0 SHALL leave credits unchanged and SHALL set err_issue.
REQ-021 A write SHALL occur on pipe_valid_i when count<DEPTH, or when count==DEPTH and an output handshake occurs in the same cycle.
  - Write stores pipe_data_i at wr_ptr.
  - wr_ptr advances modulo DEPTH.
REQ-022 pipe_valid_i with count==DEPTH and no same-cycle handshake SHALL drop the data and set err_overflow; count and pointers SHALL be unchanged.
REQ-023 out_valid SHALL equal (count != 0).
REQ-024 out_data SHALL equal mem[rd_ptr] in first-word-fall-through style; out_data is don't-care when out_valid=0.
REQ-025 An output handshake SHALL advance rd_ptr modulo DEPTH.
REQ-026 count SHALL change as follows:
  - +1 on a write alone.
  - -1 on a read alone.
  - unchanged on a simultaneous write and read.
REQ-027 There SHALL be no empty bypass: data written into an empty FIFO appears on out_valid/out_data exactly 1 cycle after the pipe_valid_i cycle.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0 with no bubble.
REQ-029 Read and write on the same entry in the same cycle (full case) SHALL return the old head on out_data and store the new data.
REQ-030 Invariant: count + credits + items in flight == DEPTH whenever upstream honours issue_ready; if upstream does not honour it, credits SHALL saturate at 0 and never underflow.
REQ-031 credits SHALL never exceed DEPTH; an output handshake with credits==DEPTH SHALL leave credits at DEPTH.
REQ-032 out_ready asserted with out_valid=0 SHALL have no effect.

Reset
REQ-033 On a clock edge with reset=1 the block SHALL apply:
  - credits=DEPTH, count=0, rd_ptr=0, wr_ptr=0.
  - out_valid=0, issue_ready=1.
  - err_overflow=0, err_issue=0.
REQ-034 Reset SHALL override all simultaneous events; a mid-operation reset discards stored and in-flight items.
REQ-035 Memory contents SHALL NOT require reset.
REQ-036 Sticky flags SHALL clear only on reset.

Verification
REQ-037 Reset, then issue 8 items with out_ready=0 -> credits 8..0; issue_ready=0 after the 8th issue.
REQ-038 Items return via pipe_valid_i with data 0x0001..0x0008 -> count=8; then out_ready=1 -> out_data 0x0001..0x0008 in order, one per cycle; credits return to 8.
REQ-039 FIFO full, same-cycle pipe_valid_i (0xBEEF) and out_ready=1 -> head popped, 0xBEEF stored, count stays 8, err_overflow=0.
REQ-040 FIFO full, pipe_valid_i (0xDEAD) with out_ready=0 -> data dropped, err_overflow=1 and stays 1, count=8.
REQ-041 credits=0, issue_fire=1 -> err_issue=1, credits stays 0; simultaneous issue and handshake at credits=3 -> credits stays 3.
REQ-042 Continuous streaming of 20 items at 1 per cycle with out_ready=1 -> pointers wrap twice, output order matches input order, reset mid-stream -> count=0, credits=8 on the next cycle.
